// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: funct3 encodings,
// controller states and the store byte-enable helper.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [0:0] {CLEAR, RUN} dmem_state_t;

    // Byte lanes touched by an access of the given size at byte offset off.
    function automatic logic [3:0] byte_mask(input logic [2:0] funct3, input logic [1:0] off);
        logic [3:0] m;
        case (funct3)
            F3_B, F3_BU: m = 4'b0001 << off;
            F3_H, F3_HU: m = 4'b0011 << off;
            F3_W:        m = 4'b1111;
            default:     m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load lane extraction: picks the addressed byte/halfword out of a memory
// word and sign- or zero-extends it according to funct3.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    output logic [31:0] rdata_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    always_comb begin
        byte_s  = word_i[{off_i, 3'b000} +: 8];
        half_s  = off_i[1] ? word_i[31:16] : word_i[15:0];
        rdata_o = '0;
        case (funct3_i)
            F3_B:    rdata_o = {{24{byte_s[7]}}, byte_s};
            F3_H:    rdata_o = {{16{half_s[15]}}, half_s};
            F3_W:    rdata_o = word_i;
            F3_BU:   rdata_o = {24'd0, byte_s};
            F3_HU:   rdata_o = {16'd0, half_s};
            default: rdata_o = '0;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Byte-addressable data memory for the RV32I MEM stage: optional post-reset
// clear sweep, one request per cycle, fixed-latency response with fault flag.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH          = 128,
    parameter int LATENCY        = 1,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic        busy_clear_o,
    output dmem_state_t dbg_state_o
);

    // Handshake: a request transfers on a rising edge where req_valid_i and
    // req_ready_o are both high; the response is a one-cycle resp_valid_o
    // pulse LATENCY cycles later and cannot be stalled by the consumer.

    localparam int AW = $clog2(DEPTH);
    localparam dmem_state_t RESET_STATE = CLEAR_ON_RESET ? CLEAR : RUN;

    dmem_state_t       state_q, state_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic              ready_en_q;
    logic [31:0]       mem_q [DEPTH];

    logic              accept;
    logic              fault;
    logic [AW-1:0]     idx;
    logic [1:0]        off;
    logic [3:0]        mask;
    logic [31:0]       wdata_rep;
    logic [31:0]       load_data;
    logic [31:0]       s0_rdata_d;

    logic [LATENCY-1:0] vld_q;
    logic [LATENCY-1:0] err_q;
    logic [31:0]        rdata_q [LATENCY];

    assign idx  = req_addr_i[AW+1:2];
    assign off  = req_addr_i[1:0];
    assign mask = byte_mask(req_funct3_i, off);

    // ready_en_q keeps req_ready low for the first cycle out of reset even
    // when the sweep is skipped.
    assign req_ready_o  = (state_q == RUN) && ready_en_q;
    assign busy_clear_o = (state_q == CLEAR);
    assign dbg_state_o  = state_q;
    assign accept       = req_valid_i && req_ready_o;

    always_comb begin
        fault = 1'b0;
        if (req_funct3_i == 3'b011 || req_funct3_i[2:1] == 2'b11) fault = 1'b1;
        if (req_we_i && req_funct3_i[2])                          fault = 1'b1;
        if (req_funct3_i[1:0] == 2'b01 && req_addr_i[0])          fault = 1'b1;
        if (req_funct3_i == F3_W && req_addr_i[1:0] != 2'b00)     fault = 1'b1;
        if (|req_addr_i[31:AW+2])                                 fault = 1'b1;
    end

    always_comb begin
        wdata_rep = req_wdata_i;
        case (req_funct3_i[1:0])
            2'b00:   wdata_rep = {4{req_wdata_i[7:0]}};
            2'b01:   wdata_rep = {2{req_wdata_i[15:0]}};
            default: wdata_rep = req_wdata_i;
        endcase
    end

    dmem_load_align u_align (
        .word_i   (mem_q[idx]),
        .funct3_i (req_funct3_i),
        .off_i    (off),
        .rdata_o  (load_data)
    );

    assign s0_rdata_d = (accept && !req_we_i && !fault) ? load_data : 32'd0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == AW'(DEPTH - 1)) state_d = RUN;
            end
            RUN:     state_d = RUN;
            default: state_d = RESET_STATE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= RESET_STATE;
            cnt_q      <= '0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ready_en_q <= 1'b1;
        end
    end

    // Storage has no reset; the sweep and stores never coincide because
    // req_ready_o is low throughout CLEAR.
    always_ff @(posedge clk_i) begin
        if (state_q == CLEAR) begin
            mem_q[cnt_q] <= 32'd0;
        end else if (accept && req_we_i && !fault) begin
            for (int i = 0; i < 4; i++) begin
                if (mask[i]) mem_q[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= '0;
            err_q <= '0;
            for (int i = 0; i < LATENCY; i++) rdata_q[i] <= 32'd0;
        end else begin
            vld_q[0]   <= accept;
            err_q[0]   <= accept && fault;
            rdata_q[0] <= s0_rdata_d;
            for (int i = 1; i < LATENCY; i++) begin
                vld_q[i]   <= vld_q[i-1];
                err_q[i]   <= err_q[i-1];
                rdata_q[i] <= rdata_q[i-1];
            end
        end
    end

    assign resp_valid_o = vld_q[LATENCY-1];
    assign resp_err_o   = err_q[LATENCY-1];
    assign resp_rdata_o = rdata_q[LATENCY-1];

endmodule
